// File: rtl/buspirate_core.sv
// Bus Pirate FPGA core: MCU register slave, five configurable pin buffers, latch port
// and a mode-0 SPI byte engine. SRAM ports are parked.
module buspirate_core #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     bufdir_mosi,
  output logic                     bufod_mosi,
  inout  wire                      bufio_mosi,
  output logic                     bufdir_clock,
  output logic                     bufod_clock,
  inout  wire                      bufio_clock,
  output logic                     bufdir_miso,
  output logic                     bufod_miso,
  inout  wire                      bufio_miso,
  output logic                     bufdir_cs,
  output logic                     bufod_cs,
  inout  wire                      bufio_cs,
  output logic                     bufdir_aux,
  output logic                     bufod_aux,
  inout  wire                      bufio_aux,
  output logic [7:0]               lat,
  output logic                     lat_oe,
  input  logic                     mc_oe,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
  output logic                     irq0,
  output logic                     irq1,
  output logic                     sram_clock,
  output logic                     sram0_cs,
  output logic                     sram1_cs,
  inout  wire  [3:0]               sram0_sio,
  inout  wire  [3:0]               sram1_sio,
  output logic [1:0]               dbg_spi_state
);

  localparam logic [MC_ADD_WIDTH-1:0] A_LAT  = 'h00;
  localparam logic [MC_ADD_WIDTH-1:0] A_DIR  = 'h10;
  localparam logic [MC_ADD_WIDTH-1:0] A_OD   = 'h11;
  localparam logic [MC_ADD_WIDTH-1:0] A_OUT  = 'h12;
  localparam logic [MC_ADD_WIDTH-1:0] A_IN   = 'h13;
  localparam logic [MC_ADD_WIDTH-1:0] A_TX   = 'h18;
  localparam logic [MC_ADD_WIDTH-1:0] A_CTRL = 'h19;
  localparam logic [MC_ADD_WIDTH-1:0] A_RX   = 'h1A;

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} spi_state_t;

  logic [2:0] r_we_s;
  logic [4:0] r_pin_s1, r_pin_s2;
  logic       r_aux_prev;
  logic [7:0] r_lat, r_tx, r_tx_sh, r_rx_sh, r_rx;
  logic       r_lat_oe, r_en, r_start, r_irq0, r_irq1;
  logic [4:0] r_dir, r_od, r_out, r_cnt;
  spi_state_t r_state, w_next;

  logic       w_wr, w_rd_en, w_rd_in, w_done, w_sck_rise, w_sck_fall;
  logic       w_spi_cs_n, w_spi_sck, w_spi_mosi, w_spi_busy;
  logic [4:0] w_pin_in, w_dir, w_val;
  logic [MC_DATA_WIDTH-1:0] w_rd_data;
  logic       w_unused;

  // mc_we is asynchronous to clock: a write commits once, on the rising edge of the
  // synchronized strobe, with mc_add/mc_data held stable by the MCU until then.
  assign w_wr     = r_we_s[1] & ~r_we_s[2];
  assign w_rd_en  = ~mc_ce & ~mc_oe & ~mc_we;
  assign w_rd_in  = w_rd_en && (mc_add == A_IN);
  assign w_pin_in = {bufio_aux, bufio_cs, bufio_miso, bufio_clock, bufio_mosi};
  assign w_unused = ^mc_data[MC_DATA_WIDTH-1:8];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we_s   <= '0;
      r_lat    <= '0;
      r_lat_oe <= 1'b1;
      r_dir    <= '0;
      r_od     <= '0;
      r_out    <= '0;
      r_tx     <= '0;
      r_en     <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_we_s  <= {r_we_s[1:0], mc_we};
      r_start <= w_wr && (mc_add == A_CTRL) && mc_data[1] && mc_data[0] && (r_state == S_IDLE);
      if (w_wr) begin
        case (mc_add)
          A_LAT:   begin r_lat <= mc_data[7:0]; r_lat_oe <= 1'b0; end
          A_DIR:   r_dir <= mc_data[4:0];
          A_OD:    r_od  <= mc_data[4:0];
          A_OUT:   r_out <= mc_data[4:0];
          A_TX:    r_tx  <= mc_data[7:0];
          A_CTRL:  r_en  <= mc_data[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pin_s1   <= '0;
      r_pin_s2   <= '0;
      r_aux_prev <= 1'b0;
      r_irq0     <= 1'b0;
      r_irq1     <= 1'b0;
      r_rx       <= '0;
    end else begin
      r_pin_s1   <= w_pin_in;
      r_pin_s2   <= r_pin_s1;
      r_aux_prev <= r_pin_s2[4];
      if (r_pin_s2[4] != r_aux_prev) r_irq1 <= 1'b1;
      else if (w_rd_in)              r_irq1 <= 1'b0;
      if (w_done) begin
        r_irq0 <= 1'b1;
        r_rx   <= r_rx_sh;
      end else if (w_wr && (mc_add == A_CTRL)) begin
        r_irq0 <= 1'b0;
      end
    end
  end

  // SPI FSM: LEAD (2 clk, cs low) -> SHIFT (8 x 4 clk SCK periods) -> TRAIL (2 clk).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!r_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_start)        w_next = S_LEAD;
        S_LEAD:  if (r_cnt == 5'd1)  w_next = S_SHIFT;
        S_SHIFT: if (r_cnt == 5'd31) w_next = S_TRAIL;
        S_TRAIL: if (r_cnt == 5'd1)  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_spi_cs_n = 1'b1;
    w_spi_sck  = 1'b0;
    w_spi_busy = 1'b0;
    w_spi_mosi = 1'b0;
    case (r_state)
      S_LEAD:  begin w_spi_cs_n = 1'b0; w_spi_busy = 1'b1; w_spi_mosi = r_tx_sh[7]; end
      S_SHIFT: begin
        w_spi_cs_n = 1'b0;
        w_spi_busy = 1'b1;
        w_spi_sck  = ~r_cnt[1];
        w_spi_mosi = r_tx_sh[7];
      end
      S_TRAIL: begin w_spi_cs_n = 1'b0; w_spi_busy = 1'b1; end
      default: ;
    endcase
  end

  assign w_sck_rise = ((r_state == S_LEAD) && (r_cnt == 5'd1)) ||
                      ((r_state == S_SHIFT) && (r_cnt[1:0] == 2'd3) && (r_cnt != 5'd31));
  assign w_sck_fall = (r_state == S_SHIFT) && (r_cnt[1:0] == 2'd1);
  assign w_done     = r_en && (r_state == S_TRAIL) && (r_cnt == 5'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? 5'd0 : r_cnt + 5'd1;
      if ((r_state == S_IDLE) && (w_next == S_LEAD)) r_tx_sh <= r_tx;
      else if (w_sck_fall)                           r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      if (w_sck_rise) r_rx_sh <= {r_rx_sh[6:0], r_pin_s2[2]};
    end
  end

  // Open-drain outputs only ever pull low; a high OUT releases the pin.
  always_comb begin
    w_dir = '0;
    w_val = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_dir[i] && !r_od[i]) begin
        w_dir[i] = 1'b1;
        w_val[i] = r_out[i];
      end else if (r_dir[i] && r_od[i]) begin
        w_dir[i] = ~r_out[i];
      end
    end
    if (r_en) begin
      w_dir[3:0] = 4'b1011;
      w_val[3:0] = {w_spi_cs_n, 1'b0, w_spi_sck, w_spi_mosi};
    end
  end

  assign bufdir_mosi  = w_dir[0];
  assign bufdir_clock = w_dir[1];
  assign bufdir_miso  = w_dir[2];
  assign bufdir_cs    = w_dir[3];
  assign bufdir_aux   = w_dir[4];
  assign bufod_mosi   = r_od[0];
  assign bufod_clock  = r_od[1];
  assign bufod_miso   = r_od[2];
  assign bufod_cs     = r_od[3];
  assign bufod_aux    = r_od[4];
  assign bufio_mosi   = w_dir[0] ? w_val[0] : 1'bz;
  assign bufio_clock  = w_dir[1] ? w_val[1] : 1'bz;
  assign bufio_miso   = w_dir[2] ? w_val[2] : 1'bz;
  assign bufio_cs     = w_dir[3] ? w_val[3] : 1'bz;
  assign bufio_aux    = w_dir[4] ? w_val[4] : 1'bz;

  always_comb begin
    w_rd_data = '0;
    case (mc_add)
      A_LAT:   w_rd_data[7:0] = r_lat;
      A_DIR:   w_rd_data[4:0] = r_dir;
      A_OD:    w_rd_data[4:0] = r_od;
      A_OUT:   w_rd_data[4:0] = r_out;
      A_IN:    w_rd_data[4:0] = r_pin_s2;
      A_TX:    w_rd_data[7:0] = r_tx;
      A_CTRL:  w_rd_data[2:0] = {w_spi_busy, 1'b0, r_en};
      A_RX:    w_rd_data[7:0] = r_rx;
      default: ;
    endcase
  end

  assign mc_data       = w_rd_en ? w_rd_data : {MC_DATA_WIDTH{1'bz}};
  assign lat           = r_lat;
  assign lat_oe        = r_lat_oe;
  assign irq0          = r_irq0;
  assign irq1          = r_irq1;
  assign sram_clock    = 1'b0;
  assign sram0_cs      = 1'b1;
  assign sram1_cs      = 1'b1;
  assign sram0_sio     = 4'bzzzz;
  assign sram1_sio     = 4'bzzzz;
  assign dbg_spi_state = r_state;

endmodule

// File: tb/tb_buspirate_core.sv
// Directed bench for buspirate_core: latch, pin modes, SPI transfers, irq1 and
// asynchronous reset during a transfer.
module tb_buspirate_core;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wire        bufio_mosi, bufio_clock, bufio_miso, bufio_cs, bufio_aux;
  logic       bufdir_mosi, bufdir_clock, bufdir_miso, bufdir_cs, bufdir_aux;
  logic       bufod_mosi, bufod_clock, bufod_miso, bufod_cs, bufod_aux;
  logic [7:0] lat;
  logic       lat_oe, irq0, irq1, sram_clock, sram0_cs, sram1_cs;
  logic       mc_oe, mc_ce, mc_we;
  logic [5:0] mc_add;
  wire [15:0] mc_data;
  wire [3:0]  sram0_sio, sram1_sio;
  logic [1:0] dbg_spi_state;

  logic        tb_miso, tb_miso_en, tb_aux, tb_aux_en, tb_den;
  logic [15:0] tb_data, rd;
  logic [0:0]  exp_q[$];
  logic [7:0]  tx_byte;
  int          checks = 0;
  int          errors = 0;
  int          cs_low, rises;

  assign bufio_miso = tb_miso_en ? tb_miso : 1'bz;
  assign bufio_aux  = tb_aux_en ? tb_aux : 1'bz;
  assign mc_data    = tb_den ? tb_data : 16'hzzzz;

  buspirate_core dut (
    .clock(clock), .reset(reset),
    .bufdir_mosi(bufdir_mosi), .bufod_mosi(bufod_mosi), .bufio_mosi(bufio_mosi),
    .bufdir_clock(bufdir_clock), .bufod_clock(bufod_clock), .bufio_clock(bufio_clock),
    .bufdir_miso(bufdir_miso), .bufod_miso(bufod_miso), .bufio_miso(bufio_miso),
    .bufdir_cs(bufdir_cs), .bufod_cs(bufod_cs), .bufio_cs(bufio_cs),
    .bufdir_aux(bufdir_aux), .bufod_aux(bufod_aux), .bufio_aux(bufio_aux),
    .lat(lat), .lat_oe(lat_oe),
    .mc_oe(mc_oe), .mc_ce(mc_ce), .mc_we(mc_we), .mc_add(mc_add), .mc_data(mc_data),
    .irq0(irq0), .irq1(irq1),
    .sram_clock(sram_clock), .sram0_cs(sram0_cs), .sram1_cs(sram1_cs),
    .sram0_sio(sram0_sio), .sram1_sio(sram1_sio),
    .dbg_spi_state(dbg_spi_state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle mc_we strobe; address/data stay driven until the caller releases them.
  task automatic strobe(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    mc_add = a; tb_data = d; tb_den = 1'b1; mc_we = 1'b1;
    @(negedge clock);
    mc_we = 1'b0;
  endtask

  task automatic mc_write(input logic [5:0] a, input logic [15:0] d);
    strobe(a, d);
    repeat (4) @(negedge clock);
    tb_den = 1'b0;
  endtask

  task automatic mc_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clock);
    tb_den = 1'b0; mc_add = a; mc_ce = 1'b0; mc_oe = 1'b0;
    @(negedge clock);
    d = mc_data;
    mc_ce = 1'b1; mc_oe = 1'b1;
  endtask

  // Starts a transfer and watches cs/sck/mosi on every falling clock edge.
  task automatic spi_xfer();
    logic prev_sck, seen_low;
    prev_sck = 1'b0; seen_low = 1'b0; cs_low = 0; rises = 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(tx_byte[i]);
    strobe(6'h19, 16'h0003);
    for (int n = 0; n < 80; n++) begin
      @(negedge clock);
      if (!bufio_cs) begin cs_low++; seen_low = 1'b1; end
      if (bufio_clock && !prev_sck) begin
        rises++;
        if (exp_q.size() > 0) check("mosi_bit", 16'(bufio_mosi), 16'(exp_q.pop_front()));
      end
      prev_sck = bufio_clock;
      if (seen_low && bufio_cs) break;
    end
    tb_den = 1'b0;
    check("cs_low_clocks", 16'(cs_low), 16'd36);
    check("sck_rises", 16'(rises), 16'd8);
    check("mosi_left", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b0; mc_add = '0;
    tb_den = 1'b0; tb_data = '0; tb_miso = 1'b0; tb_miso_en = 1'b1;
    tb_aux = 1'b0; tb_aux_en = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_lat", 16'(lat), 16'h0000);
    check("rst_lat_oe", 16'(lat_oe), 16'h0001);
    check("rst_bufdir", 16'({bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi}), 16'h0000);
    check("rst_bufod", 16'({bufod_aux, bufod_cs, bufod_miso, bufod_clock, bufod_mosi}), 16'h0000);
    check("rst_irq", 16'({irq1, irq0}), 16'h0000);
    check("sram_idle", 16'({sram_clock, sram0_cs, sram1_cs}), 16'h0003);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // First latch write: visible after the third rising edge following the strobe.
    strobe(6'h00, 16'h0055);
    check("lat_oe_n1", 16'(lat_oe), 16'h0001);
    @(negedge clock);
    check("lat_oe_n2", 16'(lat_oe), 16'h0001);
    @(negedge clock);
    check("lat_oe_n3", 16'(lat_oe), 16'h0000);
    check("lat_55", 16'(lat), 16'h0055);
    repeat (2) @(negedge clock);
    tb_den = 1'b0;
    mc_write(6'h00, 16'h00FF);
    check("lat_ff", 16'(lat), 16'h00FF);
    check("lat_oe_stays", 16'(lat_oe), 16'h0000);
    mc_read(6'h00, rd);
    check("rd_lat", rd, 16'h00FF);
    mc_read(6'h05, rd);
    check("rd_unmapped", rd, 16'h0000);

    mc_write(6'h19, 16'h0002);
    repeat (4) @(negedge clock);
    check("start_no_en_dir", 16'({bufdir_cs, bufdir_clock, bufdir_mosi}), 16'h0000);
    mc_read(6'h19, rd);
    check("rd_ctrl_off", rd, 16'h0000);

    mc_write(6'h19, 16'h0001);
    check("en_dir", 16'({bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi}), 16'h000B);
    check("en_idle_lvls", 16'({bufio_cs, bufio_clock, bufio_mosi}), 16'h0004);
    mc_read(6'h19, rd);
    check("rd_ctrl_en", rd, 16'h0001);

    mc_write(6'h18, 16'h00A5);
    tx_byte = 8'hA5;
    spi_xfer();
    check("irq0_set_a", 16'(irq0), 16'h0001);
    mc_read(6'h1A, rd);
    check("rx_00", rd, 16'h0000);
    mc_read(6'h19, rd);
    check("rd_ctrl_idle", rd, 16'h0001);

    tb_miso = 1'b1;
    repeat (3) @(negedge clock);
    spi_xfer();
    check("irq0_set_b", 16'(irq0), 16'h0001);
    mc_read(6'h1A, rd);
    check("rx_ff", rd, 16'h00FF);

    // aux as open-drain: OUT=0 pulls low, OUT=1 releases the pin.
    mc_write(6'h10, 16'h0010);
    mc_write(6'h11, 16'h0010);
    check("od_low_dir", 16'({bufdir_aux, bufod_aux}), 16'h0003);
    check("od_low_io", 16'(bufio_aux), 16'h0000);
    mc_read(6'h10, rd);
    check("rd_dir", rd, 16'h0010);
    mc_write(6'h12, 16'h0010);
    check("od_high_dir", 16'({bufdir_aux, bufod_aux}), 16'h0001);
    check("irq1_quiet", 16'(irq1), 16'h0000);
    tb_aux = 1'b1; tb_aux_en = 1'b1;
    repeat (4) @(negedge clock);
    check("irq1_set", 16'(irq1), 16'h0001);
    mc_read(6'h13, rd);
    check("rd_in", rd, 16'h001C);
    check("irq1_clr", 16'(irq1), 16'h0000);

    strobe(6'h19, 16'h0003);
    repeat (10) @(negedge clock);
    check("busy_before_rst", 16'(bufio_cs), 16'h0000);
    #2 reset = 1'b0;
    #1;
    check("arst_bufdir", 16'({bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi}), 16'h0000);
    check("arst_lat", 16'({lat_oe, lat}), 16'h0100);
    check("arst_irq", 16'({irq1, irq0}), 16'h0000);
    @(negedge clock);
    tb_den = 1'b0;
    reset = 1'b1;
    mc_read(6'h1A, rd);
    check("arst_rx", rd, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
